// File: rtl/dpram_pipe_if.sv
// Bus bundle for dpram_pipe: write port, read port, clear control and status.
interface dpram_pipe_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
);
  logic            wr_en;
  logic [DW/8-1:0] wr_be;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data;
  logic            rd_valid;
  logic            init_req;
  logic            init_busy;

  modport master (
    output wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr, init_req,
    input  rd_data, rd_valid, init_busy
  );

  modport slave (
    input  wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr, init_req,
    output rd_data, rd_valid, init_busy
  );
endinterface

// File: rtl/dpram_pipe.sv
// Simple dual-port RAM with byte enables, self-clearing INIT sweep,
// configurable read latency (1 or 2) and collision policy.
module dpram_pipe #(
  parameter int unsigned     AW       = 8,
  parameter int unsigned     DW       = 32,
  parameter int unsigned     RD_LAT   = 1,
  parameter int unsigned     WR_FIRST = 1,
  parameter logic [DW-1:0]   INIT_VAL = '0
) (
  input logic         clk,
  input logic         rst_n,
  dpram_pipe_if.slave bus
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned CW    = AW + 1;

  typedef enum logic {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic          init_busy_q, init_busy_d;
  logic          p1_valid_q, p1_valid_d;
  logic [DW-1:0] p1_data_q, p1_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic [DW-1:0] mem_q [DEPTH];

  logic          mem_we_c;
  logic [AW-1:0] mem_addr_c;
  logic [DW-1:0] mem_wdata_c;
  logic [DW-1:0] mem_mask_c;
  logic [DW-1:0] be_mask_c;
  logic [DW-1:0] rd_word_c;
  logic [DW-1:0] rd_sel_c;
  logic          rd_fire_c;

  // Expand byte enables to a bit mask.
  always_comb begin
    be_mask_c = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      be_mask_c[i*8 +: 8] = {8{bus.wr_be[i]}};
    end
  end

  // Read word as seen at this edge; a same-address write is merged in when new data wins.
  always_comb begin
    rd_word_c = mem_q[bus.rd_addr];
    rd_sel_c  = rd_word_c;
    if (WR_FIRST != 0 && bus.wr_en && bus.wr_addr == bus.rd_addr) begin
      rd_sel_c = (rd_word_c & ~be_mask_c) | (bus.wr_data & be_mask_c);
    end
  end

  // Next-state, memory write port and read pipeline.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    mem_we_c    = 1'b0;
    mem_addr_c  = bus.wr_addr;
    mem_wdata_c = bus.wr_data;
    mem_mask_c  = be_mask_c;
    rd_fire_c   = 1'b0;
    p1_data_d   = p1_data_q;
    rd_data_d   = rd_data_q;

    if (state_q == ST_INIT) begin
      mem_we_c    = 1'b1;
      mem_addr_c  = clr_cnt_q[AW-1:0];
      mem_wdata_c = INIT_VAL;
      mem_mask_c  = '1;
      if (clr_cnt_q == CW'(DEPTH - 1)) begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + CW'(1);
      end
    end else begin
      mem_we_c  = bus.wr_en;
      rd_fire_c = bus.rd_en;
      if (bus.init_req) begin
        state_d   = ST_INIT;
        clr_cnt_d = '0;
      end
    end

    init_busy_d = (state_d == ST_INIT);

    p1_valid_d = rd_fire_c;
    if (rd_fire_c) p1_data_d = rd_sel_c;

    if (RD_LAT == 1) begin
      rd_valid_d = rd_fire_c;
      if (rd_fire_c) rd_data_d = rd_sel_c;
    end else begin
      rd_valid_d = p1_valid_q;
      if (p1_valid_q) rd_data_d = p1_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      clr_cnt_q   <= '0;
      init_busy_q <= 1'b1;
      p1_valid_q  <= 1'b0;
      p1_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_busy_q <= init_busy_d;
      p1_valid_q  <= p1_valid_d;
      p1_data_q   <= p1_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Storage array is not reset; contents come only from the clear sweep and writes.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_addr_c] <= (mem_q[mem_addr_c] & ~mem_mask_c) | (mem_wdata_c & mem_mask_c);
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.init_busy = init_busy_q;

endmodule

// File: tb/tb_dpram_pipe.sv
// Scoreboard bench: two instances (RD_LAT=1/new-data, RD_LAT=2/old-data) share stimulus.
module tb_dpram_pipe;

  localparam logic [15:0] IV = 16'hA5A5;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   clr_left;
  logic [15:0] mdl [16];
  logic [15:0] last [2];
  exp_t qa[$];
  exp_t qb[$];

  dpram_pipe_if #(.AW(4), .DW(16)) bus_a ();
  dpram_pipe_if #(.AW(4), .DW(16)) bus_b ();

  assign bus_b.wr_en    = bus_a.wr_en;
  assign bus_b.wr_be    = bus_a.wr_be;
  assign bus_b.wr_addr  = bus_a.wr_addr;
  assign bus_b.wr_data  = bus_a.wr_data;
  assign bus_b.rd_en    = bus_a.rd_en;
  assign bus_b.rd_addr  = bus_a.rd_addr;
  assign bus_b.init_req = bus_a.init_req;

  dpram_pipe #(.AW(4), .DW(16), .RD_LAT(1), .WR_FIRST(1), .INIT_VAL(IV)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
  );
  dpram_pipe #(.AW(4), .DW(16), .RD_LAT(2), .WR_FIRST(0), .INIT_VAL(IV)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: compare each rd_valid pulse against the front of the scoreboard.
  task automatic mon(input int idx, input logic v, input logic [15:0] d, input logic rn);
    exp_t e;
    bit   have;
    have = (idx == 0) ? (qa.size() > 0) : (qb.size() > 0);
    if (have) e = (idx == 0) ? qa[0] : qb[0];
    if (!rn) begin
      chk($sformatf("rst_valid_%0d", idx), 32'(v), 32'd0);
      chk($sformatf("rst_data_%0d", idx), 32'(d), 32'd0);
      last[idx] = '0;
    end else if (v) begin
      chk($sformatf("rd_expected_%0d", idx), 32'(have), 32'd1);
      if (have) begin
        if (idx == 0) void'(qa.pop_front()); else void'(qb.pop_front());
        chk($sformatf("rd_data_%0d", idx), 32'(d), 32'(e.data));
        chk($sformatf("rd_cycle_%0d", idx), 32'(cyc), 32'(e.due));
      end
      last[idx] = d;
    end else begin
      chk($sformatf("rd_hold_%0d", idx), 32'(d), 32'(last[idx]));
      if (have && e.due <= cyc) begin
        chk($sformatf("rd_valid_missing_%0d", idx), 32'(v), 32'd1);
        if (idx == 0) void'(qa.pop_front()); else void'(qb.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus_a.rd_valid, bus_a.rd_data, rst_n);
    mon(1, bus_b.rd_valid, bus_b.rd_data, rst_n);
  end

  // One clock of stimulus; the model applies the same edge at a transaction level.
  task automatic step(input bit we, input logic [1:0] be, input logic [3:0] wa,
                      input logic [15:0] wd, input bit re, input logic [3:0] ra,
                      input bit ir);
    logic [15:0] m, old, nw;
    exp_t e;
    bus_a.wr_en    = we;
    bus_a.wr_be    = be;
    bus_a.wr_addr  = wa;
    bus_a.wr_data  = wd;
    bus_a.rd_en    = re;
    bus_a.rd_addr  = ra;
    bus_a.init_req = ir;
    m = {{8{be[1]}}, {8{be[0]}}};
    if (clr_left > 0) begin
      mdl[16 - clr_left] = IV;
      clr_left--;
    end else begin
      old = mdl[ra];
      nw  = (mdl[wa] & ~m) | (wd & m);
      if (re) begin
        e.data = (we && wa == ra) ? nw : old;
        e.due  = cyc + 1;
        qa.push_back(e);
        e.data = old;
        e.due  = cyc + 2;
        qb.push_back(e);
      end
      if (we) mdl[wa] = nw;
      if (ir) clr_left = 16;
    end
    @(posedge clk);
    @(negedge clk);
    chk("init_busy_a", 32'(bus_a.init_busy), 32'(clr_left > 0));
    chk("init_busy_b", 32'(bus_b.init_busy), 32'(clr_left > 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 4'd0, 16'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    step(1'b1, be, a, d, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b0, 2'b00, 4'd0, 16'd0, 1'b1, a, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    last[0]  = '0;
    last[1]  = '0;
    rst_n    = 1'b0;
    bus_a.wr_en = 1'b0; bus_a.wr_be = '0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_a.rd_en = 1'b0; bus_a.rd_addr = '0; bus_a.init_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy_a", 32'(bus_a.init_busy), 32'd1);
    chk("reset_busy_b", 32'(bus_b.init_busy), 32'd1);
    #2 rst_n = 1'b1;
    clr_left = 16;

    // Clear after reset, then read every entry.
    idle(16);
    for (int i = 0; i < 16; i++) rd(4'(i));
    idle(3);

    // Byte-enable merge.
    wr(4'd3, 16'h1234, 2'b11);
    wr(4'd3, 16'hFF00, 2'b10);
    rd(4'd3);
    idle(2);
    chk("be_model", 32'(mdl[3]), 32'h0000_FF34);

    // Same-address collision.
    wr(4'd5, 16'h0001, 2'b11);
    step(1'b1, 2'b11, 4'd5, 16'hBEEF, 1'b1, 4'd5, 1'b0);
    idle(2);

    // Back-to-back reads.
    rd(4'd0); rd(4'd1); rd(4'd2);
    idle(3);

    // Re-init with a read in the request cycle; a write during clear is dropped.
    step(1'b0, 2'b00, 4'd0, 16'd0, 1'b1, 4'd3, 1'b1);
    wr(4'd2, 16'h7777, 2'b11);
    idle(15);
    rd(4'd2);
    idle(2);

    // Randomized traffic with occasional re-init.
    for (int i = 0; i < 500; i++) begin
      logic [3:0] wa, ra;
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), wa,
           16'($urandom), 1'($urandom_range(0, 1)), ra,
           ($urandom_range(0, 79) == 0));
    end
    idle(20);

    // Reset in the middle of a clear sweep.
    step(1'b0, 2'b00, 4'd0, 16'd0, 1'b0, 4'd0, 1'b1);
    idle(9);
    #2 rst_n = 1'b0;
    qa.delete();
    qb.delete();
    clr_left = 16;
    @(negedge clk);
    chk("midreset_busy_a", 32'(bus_a.init_busy), 32'd1);
    chk("midreset_busy_b", 32'(bus_b.init_busy), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(16);
    for (int i = 0; i < 16; i++) rd(4'(i));
    idle(4);

    chk("drain_a", 32'(qa.size()), 32'd0);
    chk("drain_b", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
